// File: rtl/ofm_rdma.sv
// rtl/ofm_rdma.sv - 2-D descriptor driven OFM SRAM read DMA with first/last tagged output stream
//
// Purpose: takes a 2-D descriptor (base, dim0/dim1 size and step) and walks the
// address pattern inner loop first. It drives a synchronous SRAM read port and
// returns the read data through a small credit-managed FIFO as a valid/ready stream.
//
// Optional feature: define OFM_RDMA_STALL_CNT_EN to add the stall_cnt output, a
// saturating count of backpressure cycles since the last descriptor accept.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_*             descriptor fields, start_valid/start_ready handshake
//   sram_addr, sram_en  SRAM read request, one read per cycle while sram_en is high
//   sram_rdata          SRAM read data, valid RL cycles after sram_en
//   s_data/s_first/s_last/s_valid/s_ready   output stream
//   stall_cnt           (optional) backpressure cycle counter
module ofm_rdma #(
  parameter int DW = 144,
  parameter int AW = 11,
  parameter int RL = 1,
  parameter int FD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] start_base,
  input  logic [3:0]    start_dim0_size,
  input  logic [3:0]    start_dim0_step,
  input  logic [3:0]    start_dim1_size,
  input  logic [3:0]    start_dim1_step,
  input  logic          start_valid,
  output logic          start_ready,
  output logic [AW-1:0] sram_addr,
  output logic          sram_en,
  input  logic [DW-1:0] sram_rdata,
  output logic [DW-1:0] s_data,
  output logic          s_first,
  output logic          s_last,
  output logic          s_valid,
`ifdef OFM_RDMA_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  input  logic          s_ready
);

  // CW must hold fifo_count + inflight, which never exceeds FD.
  localparam int CW = $clog2(FD + 1) + 1;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, row_q, row_d;
  logic [3:0]    i0_q, i0_d, i1_q, i1_d;
  logic [3:0]    d0s_q, d0s_d, d0st_q, d0st_d, d1s_q, d1s_d, d1st_q, d1st_d;
  logic          first_q, first_d;
  logic [RL-1:0] pen_q, pen_d, pfi_q, pfi_d, pla_q, pla_d;
  logic [CW-1:0] infl_q, infl_d, cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DW+1:0] mem_q [FD];

  logic          accept, credit, is_last, ret, pop;
  logic [AW-1:0] step0_ext, step1_ext;
  logic [DW+1:0] head;

  assign start_ready = (state_q == IDLE);
  assign accept      = start_valid && start_ready;
  // A read is only issued when a FIFO slot is guaranteed for its return data.
  assign credit      = (cnt_q + infl_q) < CW'(FD);
  assign sram_en     = (state_q == RUN) && credit;
  assign sram_addr   = addr_q;
  assign is_last     = (i0_q == d0s_q) && (i1_q == d1s_q);
  assign ret         = pen_q[RL-1];
  assign step0_ext   = {{(AW-4){1'b0}}, d0st_q};
  assign step1_ext   = {{(AW-4){1'b0}}, d1st_q};

  assign head    = mem_q[rd_q];
  assign s_valid = (cnt_q != '0);
  assign s_data  = s_valid ? head[DW-1:0] : '0;
  assign s_first = s_valid & head[DW];
  assign s_last  = s_valid & head[DW+1];
  assign pop     = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    row_d   = row_q;
    i0_d    = i0_q;
    i1_d    = i1_q;
    d0s_d   = d0s_q;
    d0st_d  = d0st_q;
    d1s_d   = d1s_q;
    d1st_d  = d1st_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          d0s_d   = start_dim0_size;
          d0st_d  = start_dim0_step;
          d1s_d   = start_dim1_size;
          d1st_d  = start_dim1_step;
          addr_d  = start_base;
          row_d   = start_base;
          i0_d    = '0;
          i1_d    = '0;
          first_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sram_en) begin
          first_d = 1'b0;
          if (is_last) state_d = DRAIN;
          // Row end: next row starts one outer step past the current row start.
          if (i0_q == d0s_q) begin
            i0_d   = '0;
            i1_d   = i1_q + 4'd1;
            row_d  = row_q + step1_ext;
            addr_d = row_q + step1_ext;
          end else begin
            i0_d   = i0_q + 4'd1;
            addr_d = addr_q + step0_ext;
          end
        end
      end
      DRAIN: begin
        if (pop && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipeline mirrors the SRAM read latency so tags meet their data.
  always_comb begin
    pen_d    = '0;
    pfi_d    = '0;
    pla_d    = '0;
    pen_d[0] = sram_en;
    pfi_d[0] = sram_en & first_q;
    pla_d[0] = sram_en & is_last;
    for (int i = 1; i < RL; i++) begin
      pen_d[i] = pen_q[i-1];
      pfi_d[i] = pfi_q[i-1];
      pla_d[i] = pla_q[i-1];
    end
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    infl_d = infl_q;
    if (ret) wr_d = (wr_q == PW'(FD - 1)) ? '0 : wr_q + PW'(1);
    if (pop) rd_d = (rd_q == PW'(FD - 1)) ? '0 : rd_q + PW'(1);
    case ({ret, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({sram_en, ret})
      2'b10:   infl_d = infl_q + CW'(1);
      2'b01:   infl_d = infl_q - CW'(1);
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      row_q   <= '0;
      i0_q    <= '0;
      i1_q    <= '0;
      d0s_q   <= '0;
      d0st_q  <= '0;
      d1s_q   <= '0;
      d1st_q  <= '0;
      first_q <= 1'b0;
      pen_q   <= '0;
      pfi_q   <= '0;
      pla_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
      d0s_q   <= d0s_d;
      d0st_q  <= d0st_d;
      d1s_q   <= d1s_d;
      d1st_q  <= d1st_d;
      first_q <= first_d;
      pen_q   <= pen_d;
      pfi_q   <= pfi_d;
      pla_q   <= pla_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      infl_q  <= infl_d;
    end
  end

  // Storage needs no reset: s_* outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (ret) mem_q[wr_q] <= {pla_q[RL-1], pfi_q[RL-1], sram_rdata};
  end

`ifdef OFM_RDMA_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept) stall_d = '0;
    else if ((state_q != IDLE) && s_valid && !s_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ofm_rdma.sv
// tb/tb_ofm_rdma.sv - directed self-checking bench for ofm_rdma
module tb_ofm_rdma;
  localparam int DW = 144;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] start_base;
  logic [3:0]    start_dim0_size, start_dim0_step, start_dim1_size, start_dim1_step;
  logic          start_valid;
  logic          start_ready;
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] s_data;
  logic          s_first, s_last, s_valid;
  logic          s_ready;
`ifdef OFM_RDMA_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [AW-1:0] addr_log[$];
  logic [DW+1:0] beat_log[$];

  always #5 clk = ~clk;

  ofm_rdma #(.DW(DW), .AW(AW), .RL(1), .FD(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_base(start_base),
    .start_dim0_size(start_dim0_size), .start_dim0_step(start_dim0_step),
    .start_dim1_size(start_dim1_size), .start_dim1_step(start_dim1_step),
    .start_valid(start_valid), .start_ready(start_ready),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_rdata(sram_rdata),
    .s_data(s_data), .s_first(s_first), .s_last(s_last), .s_valid(s_valid),
`ifdef OFM_RDMA_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .s_ready(s_ready)
  );

  function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
    return {16'hA5A5, 117'd0, a};
  endfunction

  // One-cycle-latency SRAM whose word encodes its own address.
  always @(posedge clk) begin
    if (sram_en) sram_rdata <= mk(sram_addr);
  end

  always @(posedge clk) begin
    if (rst_n && sram_en) addr_log.push_back(sram_addr);
    if (rst_n && s_valid && s_ready) beat_log.push_back({s_last, s_first, s_data});
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] b, input logic [3:0] s0, input logic [3:0] t0,
                      input logic [3:0] s1, input logic [3:0] t1);
    start_base = b;
    start_dim0_size = s0;
    start_dim0_step = t0;
    start_dim1_size = s1;
    start_dim1_step = t1;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int c = 0;
    while (beat_log.size() < target && c < budget) begin
      tick();
      c++;
    end
    check(tag, beat_log.size(), target);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (!start_ready && c < budget) begin
      tick();
      c++;
    end
    check(tag, start_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, start_ready, 1'b1);
    check({tag, "_sram_en"}, sram_en, 1'b0);
    check({tag, "_sram_addr"}, sram_addr, 11'h000);
    check({tag, "_s_valid"}, s_valid, 1'b0);
    check({tag, "_s_first"}, s_first, 1'b0);
    check({tag, "_s_last"}, s_last, 1'b0);
    check({tag, "_s_data"}, s_data, 144'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab, bb, k;
    logic [AW-1:0] exp1 [8];
    logic [AW-1:0] exp3 [4];
    logic [AW-1:0] exp5 [4];
    logic [AW-1:0] ea;

    exp1 = '{11'h010, 11'h011, 11'h012, 11'h013, 11'h018, 11'h019, 11'h01A, 11'h01B};
    exp3 = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    exp5 = '{11'h200, 11'h201, 11'h204, 11'h205};

    rst_n = 1'b0;
    start_valid = 1'b0;
    start_base = '0;
    start_dim0_size = '0;
    start_dim0_step = '0;
    start_dim1_size = '0;
    start_dim1_step = '0;
    s_ready = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Basic 2-D read with latency and end-of-transfer timing.
    ab = addr_log.size();
    bb = beat_log.size();
    send(11'h010, 4'd3, 4'd1, 4'd1, 4'd8);
    check("t1_en_after_accept", sram_en, 1'b1);
    check("t1_addr0", sram_addr, 11'h010);
    check("t1_rdy_low_run", start_ready, 1'b0);
    tick();
    check("t1_no_early_valid", s_valid, 1'b0);
    tick();
    check("t1_first_valid", s_valid, 1'b1);
    check("t1_first_tag", s_first, 1'b1);
    check("t1_first_data", s_data, mk(11'h010));
    wait_beats("t1_beats7", bb + 7, 20);
    check("t1_rdy_low_lastbeat", start_ready, 1'b0);
    check("t1_last_valid", {s_valid, s_last}, 2'b11);
    tick();
    check("t1_beats8", beat_log.size(), bb + 8);
    check("t1_rdy_after_last", start_ready, 1'b1);
    check("t1_addr_count", addr_log.size() - ab, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_addr%0d", i), addr_log[ab + i], exp1[i]);
      check($sformatf("t1_beat%0d", i), beat_log[bb + i],
            {(i == 7), (i == 0), mk(exp1[i])});
    end

    // Single-beat transfer carries both tags.
    ab = addr_log.size();
    bb = beat_log.size();
    send(11'h7FF, 4'd0, 4'd0, 4'd0, 4'd0);
    wait_idle("t2_idle", 20);
    tick();
    check("t2_one_read", addr_log.size() - ab, 1);
    check("t2_addr", addr_log[ab], 11'h7FF);
    check("t2_one_beat", beat_log.size() - bb, 1);
    check("t2_beat", beat_log[bb], {1'b1, 1'b1, mk(11'h7FF)});

    // Address wrap past the top of the SRAM.
    ab = addr_log.size();
    bb = beat_log.size();
    send(11'h7FE, 4'd3, 4'd1, 4'd0, 4'd0);
    wait_idle("t3_idle", 30);
    check("t3_addr_count", addr_log.size() - ab, 4);
    check("t3_beat_count", beat_log.size() - bb, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_addr%0d", i), addr_log[ab + i], exp3[i]);
      check($sformatf("t3_beat%0d", i), beat_log[bb + i],
            {(i == 3), (i == 0), mk(exp3[i])});
    end

    // Backpressure, with a descriptor offered mid-transfer that must be ignored.
    ab = addr_log.size();
    bb = beat_log.size();
    send(11'h100, 4'd3, 4'd2, 4'd3, 4'd15);
    wait_beats("t4_beats3", bb + 3, 30);
    s_ready = 1'b0;
    start_base = 11'h555;
    start_dim0_size = 4'd0;
    start_dim1_size = 4'd0;
    start_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t4_rdy_low_viol", start_ready, 1'b0);
    check("t4_en_stopped", sram_en, 1'b0);
    check("t4_credit_fd", (addr_log.size() - ab) - (beat_log.size() - bb), 4);
    check("t4_hold_valid", s_valid, 1'b1);
    start_valid = 1'b0;
    s_ready = 1'b1;
    wait_idle("t4_idle", 60);
    check("t4_addr_count", addr_log.size() - ab, 16);
    check("t4_beat_count", beat_log.size() - bb, 16);
    k = 0;
    for (int i1 = 0; i1 < 4; i1++) begin
      for (int i0 = 0; i0 < 4; i0++) begin
        ea = 11'(11'h100 + i1 * 15 + i0 * 2);
        check($sformatf("t4_addr%0d", k), addr_log[ab + k], ea);
        check($sformatf("t4_beat%0d", k), beat_log[bb + k], {(k == 15), (k == 0), mk(ea)});
        k++;
      end
    end

    // Asynchronous reset in the middle of a 16-beat run.
    bb = beat_log.size();
    send(11'h300, 4'd3, 4'd1, 4'd3, 4'd4);
    wait_beats("t5_beats5", bb + 5, 30);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("t5_idle_after_rst", start_ready, 1'b1);
    ab = addr_log.size();
    bb = beat_log.size();
    send(11'h200, 4'd1, 4'd1, 4'd1, 4'd4);
    wait_idle("t5_idle", 30);
    check("t5_addr_count", addr_log.size() - ab, 4);
    check("t5_beat_count", beat_log.size() - bb, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_addr%0d", i), addr_log[ab + i], exp5[i]);
      check($sformatf("t5_beat%0d", i), beat_log[bb + i],
            {(i == 3), (i == 0), mk(exp5[i])});
    end

`ifdef OFM_RDMA_STALL_CNT_EN
    // Stall counter: 7 backpressured cycles, hold in IDLE, clear on accept.
    begin
      int c = 0;
      s_ready = 1'b0;
      send(11'h040, 4'd3, 4'd1, 4'd0, 4'd0);
      while (!s_valid && c < 20) begin
        tick();
        c++;
      end
      check("t6_valid_seen", s_valid, 1'b1);
      for (int i = 0; i < 7; i++) tick();
      check("t6_stall7", stall_cnt, 16'd7);
      s_ready = 1'b1;
      wait_idle("t6_idle", 30);
      tick();
      tick();
      check("t6_hold_idle", stall_cnt, 16'd7);
      send(11'h050, 4'd0, 4'd0, 4'd0, 4'd0);
      check("t6_clear", stall_cnt, 16'd0);
      wait_idle("t6_idle2", 30);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
